// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, waveform codes and mixer helper for poly_synth
package synth_pkg;

  // Per-voice envelope phases
  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // Waveform select codes, two bits per voice
  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_OFF    = 2'd3;

  // Right shift that scales the voice sum back to one sample width
  function automatic int mix_shift(input int voices);
    return (voices <= 1) ? 0 : $clog2(voices);
  endfunction

endpackage

// File: rtl/voice_env.sv
// rtl/voice_env.sv - gate-driven attack/sustain/release envelope for one voice
module voice_env
  import synth_pkg::*;
#(
  parameter int ENV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             gate,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] release_rate,
  output logic [ENV_W-1:0] level_o,
  output logic             active_o,
  output logic             start_o
);

  localparam logic [ENV_W-1:0] LEVEL_MAX = {ENV_W{1'b1}};

  env_state_t       state_q;
  logic [ENV_W-1:0] level_q;
  logic             active_q;
  logic [ENV_W:0]   up_sum;
  logic [ENV_W:0]   dn_diff;
  logic [ENV_W-1:0] up_d;
  logic [ENV_W-1:0] dn_d;

  // Saturating candidate levels for rising and falling moves
  always_comb begin
    up_sum  = {1'b0, level_q} + {1'b0, attack_rate};
    dn_diff = {1'b0, level_q} - {1'b0, release_rate};
    up_d    = up_sum[ENV_W] ? LEVEL_MAX : up_sum[ENV_W-1:0];
    dn_d    = dn_diff[ENV_W] ? '0 : dn_diff[ENV_W-1:0];
  end

  // Envelope FSM: the gate picks the direction, and the new level decides
  // whether the voice lands in SUSTAIN or IDLE on the same strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENV_IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
    end else if (sample_en) begin
      case (state_q)
        ENV_IDLE: begin
          if (gate) begin
            level_q  <= up_d;
            state_q  <= (up_d == LEVEL_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
            active_q <= 1'b1;
          end
        end
        ENV_ATTACK, ENV_RELEASE: begin
          if (gate) begin
            level_q  <= up_d;
            state_q  <= (up_d == LEVEL_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
            active_q <= 1'b1;
          end else begin
            level_q  <= dn_d;
            state_q  <= (dn_d == '0) ? ENV_IDLE : ENV_RELEASE;
            active_q <= (dn_d != '0);
          end
        end
        ENV_SUSTAIN: begin
          if (!gate) begin
            level_q  <= dn_d;
            state_q  <= (dn_d == '0) ? ENV_IDLE : ENV_RELEASE;
            active_q <= (dn_d != '0);
          end
        end
        default: begin
          state_q  <= ENV_IDLE;
          level_q  <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;
  // Note start: lets the oscillator clear its phase on the same strobe
  assign start_o  = sample_en & gate & (state_q == ENV_IDLE);

endmodule

// File: rtl/poly_synth.sv
// rtl/poly_synth.sv - polyphonic oscillator/envelope engine with mixer and PDM output
module poly_synth
  import synth_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int WIDTH      = 10,
  parameter int PHASE_W    = 24,
  parameter int ENV_W      = 16,
  parameter bit SYNC_PHASE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [VOICES-1:0]       gate,
  input  logic [VOICES*PHASE_W-1:0] freq_inc,
  input  logic [VOICES*2-1:0]     wave_sel,
  input  logic [ENV_W-1:0]        attack_rate,
  input  logic [ENV_W-1:0]        release_rate,
  output logic [WIDTH-1:0]        mix_out,
  output logic                    dout,
  output logic [VOICES-1:0]       env_active
);

  localparam int MIX_SHIFT = mix_shift(VOICES);
  localparam int SUM_W     = WIDTH + MIX_SHIFT;

  logic [VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
  logic [VOICES-1:0][ENV_W-1:0]   env_level;
  logic [VOICES-1:0]              env_start;
  logic [VOICES-1:0][WIDTH-1:0]   wave_d;
  logic [VOICES-1:0][2*WIDTH-1:0] prod_full;
  logic [VOICES-1:0][WIDTH-1:0]   prod_q, prod_d;
  logic [SUM_W-1:0]               mix_sum;
  logic [WIDTH-1:0]               mix_q, mix_d;
  logic [WIDTH:0]                 acc_q, acc_d;
  logic                           unused_bits;

  // Waveform shaping from the top bits of the phase
  function automatic logic [WIDTH-1:0] wave_of(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] ramp;
    ramp = {p[WIDTH-2:0], 1'b0};
    case (sel)
      WAVE_SAW:    return p;
      WAVE_SQUARE: return {WIDTH{p[WIDTH-1]}};
      WAVE_TRI:    return p[WIDTH-1] ? ~ramp : ramp;
      default:     return '0;
    endcase
  endfunction

  genvar gv;
  generate
    for (gv = 0; gv < VOICES; gv++) begin : g_voice
      voice_env #(
        .ENV_W (ENV_W)
      ) u_env (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .gate         (gate[gv]),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .level_o      (env_level[gv]),
        .active_o     (env_active[gv]),
        .start_o      (env_start[gv])
      );
    end
  endgenerate

  // Phase accumulators advance on the strobe; a new note may restart the phase
  always_comb begin
    phase_d = phase_q;
    if (sample_en) begin
      for (int v = 0; v < VOICES; v++) begin
        if (SYNC_PHASE && env_start[v]) phase_d[v] = '0;
        else phase_d[v] = phase_q[v] + freq_inc[v*PHASE_W +: PHASE_W];
      end
    end
  end

  // Wave times envelope amplitude, keeping the top half of the product
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      wave_d[v]    = wave_of(wave_sel[2*v +: 2], phase_q[v][PHASE_W-1 -: WIDTH]);
      prod_full[v] = {{WIDTH{1'b0}}, wave_d[v]} *
                     {{WIDTH{1'b0}}, env_level[v][ENV_W-1 -: WIDTH]};
      prod_d[v]    = prod_full[v][2*WIDTH-1 -: WIDTH];
    end
  end

  // Sum with headroom then scale down so the mix never clips; first-order
  // sigma-delta runs every clock on the registered mix
  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix_sum = mix_sum + SUM_W'(prod_q[v]);
    end
    mix_d = WIDTH'(mix_sum >> MIX_SHIFT);
    acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mix_q};
  end

  // Pipeline registers: phase, voice products, mix and PDM accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      prod_q  <= '0;
      mix_q   <= '0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      prod_q  <= prod_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
    end
  end

  assign mix_out     = mix_q;
  assign dout        = acc_q[WIDTH];
  assign unused_bits = ^prod_full ^ ^env_level;

endmodule

// File: tb/tb_poly_synth.sv
// tb/tb_poly_synth.sv - self-checking bench for poly_synth against a behavioural model
module tb_poly_synth;

  localparam int V = 4, W = 10, PW = 16, EW = 16;
  localparam int M_IDLE = 0, M_RISE = 1, M_HOLD = 2, M_FALL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            sample_en = 1'b0;
  logic [V-1:0]    gate = '0;
  logic [V*PW-1:0] freq_inc = '0;
  logic [2*V-1:0]  wave_sel = '1;
  logic [EW-1:0]   attack_rate = '0;
  logic [EW-1:0]   release_rate = '0;
  logic [W-1:0]    mix_out;
  logic            dout;
  logic [V-1:0]    env_active;

  poly_synth #(.VOICES(V), .WIDTH(W), .PHASE_W(PW), .ENV_W(EW), .SYNC_PHASE(1'b1)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .gate(gate), .freq_inc(freq_inc),
    .wave_sel(wave_sel), .attack_rate(attack_rate), .release_rate(release_rate),
    .mix_out(mix_out), .dout(dout), .env_active(env_active)
  );

  int n_checks = 0;
  int n_fail = 0;

  int m_phase[V], m_level[V], m_st[V], m_prod[V];
  int m_mix = 0, m_acc = 0;

  function automatic int wave_val(input int sel, input int p);
    case (sel)
      0: return p;
      1: return (p >= 512) ? 1023 : 0;
      2: return (p < 512) ? 2 * p : 1023 - 2 * (p - 512);
      default: return 0;
    endcase
  endfunction

  function automatic int voice_sample(input int sel, input int phase, input int level);
    return (wave_val(sel, phase / 64) * (level / 64)) / 1024;
  endfunction

  function automatic logic [V-1:0] exp_active();
    logic [V-1:0] a;
    for (int v = 0; v < V; v++) a[v] = (m_st[v] != M_IDLE);
    return a;
  endfunction

  function automatic logic exp_dout();
    return (m_acc >= 1024);
  endfunction

  // One clock edge of the reference: pipeline stages, then the note logic
  function automatic void model_edge();
    int nprod[V];
    int sum, nmix, nacc, g, ar, rr;
    if (rst) begin
      for (int v = 0; v < V; v++) begin
        m_phase[v] = 0; m_level[v] = 0; m_st[v] = M_IDLE; m_prod[v] = 0;
      end
      m_mix = 0; m_acc = 0;
      return;
    end
    nacc = (m_acc % 1024) + m_mix;
    sum = 0;
    for (int v = 0; v < V; v++) sum += m_prod[v];
    nmix = sum / 4;
    for (int v = 0; v < V; v++)
      nprod[v] = voice_sample(int'(wave_sel[2*v +: 2]), m_phase[v], m_level[v]);
    if (sample_en) begin
      ar = int'(attack_rate);
      rr = int'(release_rate);
      for (int v = 0; v < V; v++) begin
        g = int'(gate[v]);
        if (m_st[v] == M_IDLE && g == 1) m_phase[v] = 0;
        else m_phase[v] = (m_phase[v] + int'(freq_inc[v*PW +: PW])) % 65536;
        if (g == 1) begin
          if (m_st[v] != M_HOLD) begin
            m_level[v] = (m_level[v] + ar > 65535) ? 65535 : m_level[v] + ar;
            m_st[v] = (m_level[v] == 65535) ? M_HOLD : M_RISE;
          end
        end else if (m_st[v] != M_IDLE) begin
          m_level[v] = (m_level[v] - rr < 0) ? 0 : m_level[v] - rr;
          m_st[v] = (m_level[v] == 0) ? M_IDLE : M_FALL;
        end
      end
    end
    for (int v = 0; v < V; v++) m_prod[v] = nprod[v];
    m_mix = nmix;
    m_acc = nacc;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic strobe();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_en = 1'b0; gate = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    gate = 4'hF; attack_rate = 16'h4000; release_rate = 16'hFFFF;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample_en = (i == 0);
      tick();
      n_checks++;
      if (mix_out !== '0 || dout !== 1'b0 || env_active !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: mix %0d dout %0b act %h, want 0 0 0", i, mix_out, dout, env_active);
      end
    end
    rst = 1'b0; sample_en = 1'b0;
    tick();
    n_checks++;
    if (env_active !== 4'h0) begin
      n_fail++; $display("FAIL reset_release_idle: act %h want 0", env_active);
    end
    strobe();
    n_checks++;
    if (env_active !== 4'hF || env_active !== exp_active()) begin
      n_fail++; $display("FAIL reset_first_attack: act %h want f", env_active);
    end
    gate = '0;
    strobe();
    tick();
  endtask

  task automatic test_saw_wrap();
    do_reset();
    wave_sel = 8'hFC; freq_inc = '0; freq_inc[15:0] = 16'h0400;
    attack_rate = 16'hFFFF; gate = 4'h1;
    strobe();
    for (int s = 0; s < 64; s++) begin
      strobe();
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (mix_out !== W'(m_mix)) begin
          n_fail++; $display("FAIL saw_mix strobe %0d cyc %0d: got %0d want %0d", s, c, mix_out, m_mix);
        end
        if (c < 2) tick();
      end
    end
    n_checks++;
    if (mix_out !== '0 || dut.phase_q[0] !== 16'h0000) begin
      n_fail++; $display("FAIL saw_wrap: mix %0d phase %h want 0 0", mix_out, dut.phase_q[0]);
    end
  endtask

  task automatic test_envelope();
    logic [15:0] rise [4];
    rise = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    do_reset();
    wave_sel = 8'hFD; freq_inc = '0; freq_inc[15:0] = 16'h2000;
    attack_rate = 16'h4000; release_rate = 16'h8000; gate = 4'h1;
    for (int s = 0; s < 5; s++) begin
      strobe();
      tick();
      n_checks++;
      if (dut.env_level[0] !== rise[(s > 3) ? 3 : s] || env_active !== 4'h1) begin
        n_fail++; $display("FAIL env_attack s%0d: level %h act %h want %h 1", s, dut.env_level[0], env_active, rise[(s > 3) ? 3 : s]);
      end
      n_checks++;
      if (mix_out !== W'(m_mix)) begin
        n_fail++; $display("FAIL env_mix s%0d: got %0d want %0d", s, mix_out, m_mix);
      end
    end
    gate = 4'h0;
    strobe();
    n_checks++;
    if (dut.env_level[0] !== 16'h7FFF || env_active !== 4'h1) begin
      n_fail++; $display("FAIL env_release1: level %h act %h want 7fff 1", dut.env_level[0], env_active);
    end
    strobe();
    n_checks++;
    if (dut.env_level[0] !== 16'h0000 || env_active !== 4'h0) begin
      n_fail++; $display("FAIL env_release2: level %h act %h want 0 0", dut.env_level[0], env_active);
    end
  endtask

  task automatic test_full_square();
    int ones;
    do_reset();
    wave_sel = 8'hFD; freq_inc = '0; freq_inc[15:0] = 16'h8000;
    attack_rate = 16'hFFFF; gate = 4'h1;
    strobe();
    strobe();
    freq_inc = '0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (dut.prod_q[0] !== 10'd1022 || mix_out !== 10'd255) begin
      n_fail++; $display("FAIL square_level: sample %0d mix %0d want 1022 255", dut.prod_q[0], mix_out);
    end
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (dout === 1'b1) ones++;
    end
    n_checks++;
    if (ones != 255) begin
      n_fail++; $display("FAIL square_pdm_density: got %0d ones want 255", ones);
    end
    n_checks++;
    if (dout !== exp_dout()) begin
      n_fail++; $display("FAIL square_dout: got %0b want %0b", dout, exp_dout());
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    wave_sel = 8'hFC; freq_inc = '0; freq_inc[15:0] = 16'h0100;
    attack_rate = 16'h4000; release_rate = 16'h8000; gate = 4'h1;
    for (int s = 0; s < 4; s++) strobe();
    gate = 4'h0;
    strobe();
    n_checks++;
    if (dut.env_level[0] !== 16'h7FFF) begin
      n_fail++; $display("FAIL retrig_release: level %h want 7fff", dut.env_level[0]);
    end
    gate = 4'h1;
    strobe();
    n_checks++;
    if (dut.env_level[0] !== 16'hBFFF || env_active !== 4'h1) begin
      n_fail++; $display("FAIL retrig_attack: level %h act %h want bfff 1", dut.env_level[0], env_active);
    end
    n_checks++;
    if (dut.phase_q[0] !== 16'h0500 || dut.phase_q[0] !== PW'(m_phase[0])) begin
      n_fail++; $display("FAIL retrig_phase: phase %h want 0500", dut.phase_q[0]);
    end
    tick(); tick();
    n_checks++;
    if (mix_out !== W'(m_mix)) begin
      n_fail++; $display("FAIL retrig_mix: got %0d want %0d", mix_out, m_mix);
    end
  endtask

  task automatic test_reset_mid_attack();
    do_reset();
    wave_sel = 8'hFC; freq_inc = '0; freq_inc[15:0] = 16'h9000;
    attack_rate = 16'h4000; gate = 4'h1;
    strobe(); strobe();
    tick(); tick();
    n_checks++;
    if (dut.env_level[0] !== 16'h8000 || mix_out === '0) begin
      n_fail++; $display("FAIL midrst_pre: level %h mix %0d want 8000 nonzero", dut.env_level[0], mix_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (dut.env_level[0] !== 16'h0000 || env_active !== 4'h0) begin
      n_fail++; $display("FAIL midrst_idle: level %h act %h want 0 0", dut.env_level[0], env_active);
    end
    tick(); tick();
    n_checks++;
    if (mix_out !== '0) begin
      n_fail++; $display("FAIL midrst_mix: got %0d want 0", mix_out);
    end
    strobe();
    n_checks++;
    if (dut.env_level[0] !== 16'h4000 || env_active !== 4'h1) begin
      n_fail++; $display("FAIL midrst_retrig: level %h act %h want 4000 1", dut.env_level[0], env_active);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        attack_rate  = 16'($urandom_range(0, 16'h3000));
        release_rate = 16'($urandom_range(0, 16'h2000));
      end
      if ($urandom_range(0, 29) == 0) gate = 4'($urandom);
      if ($urandom_range(0, 99) == 0) wave_sel = 8'($urandom);
      if ($urandom_range(0, 99) == 0) freq_inc = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      sample_en = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++;
      if (mix_out !== W'(m_mix)) begin
        n_fail++; $display("FAIL rand_mix cyc %0d: got %0d want %0d", c, mix_out, m_mix);
      end
      n_checks++;
      if (dout !== exp_dout()) begin
        n_fail++; $display("FAIL rand_dout cyc %0d: got %0b want %0b", c, dout, exp_dout());
      end
      n_checks++;
      if (env_active !== exp_active()) begin
        n_fail++; $display("FAIL rand_active cyc %0d: got %h want %h", c, env_active, exp_active());
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    model_edge();
    test_reset();
    test_saw_wrap();
    test_envelope();
    test_full_square();
    test_retrigger();
    test_reset_mid_attack();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_synth.md
# poly_synth

Parametrised polyphonic voice engine: VOICES independent phase-accumulator oscillators with selectable waveform, each shaped by its own gate-driven attack/sustain/release envelope, summed into one mix and converted to a 1-bit first-order PDM stream. It is the next-generation replacement for the single-voice sine/saw/amp/PDM chain in the top-level synth, and drives the audio pin directly.

## Interface

Parameters:
- VOICES, 4: number of voices; power of two, ≥1.
- WIDTH, 10: sample width.
- PHASE_W, 24: phase accumulator width; ≥ WIDTH.
- ENV_W, 16: envelope level width; ≥ WIDTH.
- SYNC_PHASE, 1: when 1, a voice's phase clears on the IDLE→ATTACK transition.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  one-cycle sample-rate strobe.
- gate  in  VOICES  per-voice note gate, sampled on sample_en only.
- freq_inc  in  VOICES*PHASE_W  per-voice phase increment; voice v occupies bits [v*PHASE_W +: PHASE_W].
- wave_sel  in  VOICES*2  per-voice waveform: 0 saw, 1 square, 2 triangle, 3 off.
- attack_rate  in  ENV_W  level increment per sample, shared by all voices.
- release_rate  in  ENV_W  level decrement per sample, shared by all voices.
- mix_out  out  WIDTH  registered mixed sample.
- dout  out  1  PDM bitstream.
- env_active  out  VOICES  voice state is not IDLE.

## Operation

- Phase: on sample_en, phase += freq_inc, modulo 2^PHASE_W. p = top WIDTH bits of phase.
- Waveform:
  - saw = p.
  - square = all ones if p[MSB], else 0.
  - triangle = {p[WIDTH-2:0],0} if p[MSB]=0, else ~{p[WIDTH-2:0],0}.
  - off = 0.
- Envelope FSM per voice, advancing on sample_en only:
  - IDLE: level = 0. gate=1 → ATTACK. If SYNC_PHASE, phase clears on the same tick.
  - ATTACK: level += attack_rate, saturating at 2^ENV_W−1. Reaching max → SUSTAIN. gate=0 → RELEASE; gate has priority over reaching max.
  - SUSTAIN: level holds. gate=0 → RELEASE.
  - RELEASE: level −= release_rate, saturating at 0. Reaching 0 → IDLE. gate=1 → ATTACK from the current level, with no phase clear.
  - attack_rate=0 holds the voice in ATTACK at its current level.
- Voice sample: top WIDTH bits of (wave × level[ENV_W-1 -: WIDTH]), a 2·WIDTH-bit product.
- Mix: sum all voice samples at width WIDTH+log2(VOICES); mix_out = sum >> log2(VOICES). The mix cannot clip.
- PDM: every clk, independent of sample_en:
  - acc (WIDTH+1 bits) ← acc[WIDTH-1:0] + mix_out.
  - dout = acc[WIDTH].

## Timing

- Phase and envelope registers update in the sample_en cycle T.
- Voice products are registered at T+1. mix_out is valid at T+2. The first PDM bit reflecting the new mix_out appears at T+3.
- Back-to-back sample_en on consecutive cycles is legal; the pipeline stages advance every clk.
- Reset values: phase 0, level 0, state IDLE, voice products 0, mix_out 0, acc 0, dout 0, env_active 0.
- rst has priority over sample_en and gate in the same cycle. Reset mid-note forces IDLE on the next edge. A held gate retriggers ATTACK on the first sample_en after rst deasserts.
- freq_inc, wave_sel and the rates are sampled only on sample_en or in the product stage. Changes between strobes cause no glitch beyond one sample.

## Structure

- Package synth_pkg:
  - env_state_t enum {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE}.
  - wave codes WAVE_SAW=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_OFF=3.
  - a clog2-based MIX_SHIFT helper.
- Sub-module voice_env: one envelope FSM with level register, saturating arithmetic and an active flag; instantiated VOICES times in a generate loop.
- Oscillator, waveform, product, mixer and PDM stay in poly_synth.

## Test plan

Configuration: VOICES=4, WIDTH=10, PHASE_W=16, ENV_W=16.

- Reset: rst held 2 cycles with gate=4'hF and sample_en pulsing → mix_out=0, dout=0, env_active=0 throughout; first ATTACK on the first strobe after release.
- Saw wrap: voice0 saw, freq_inc=16'h0400 → p steps by 16 per strobe; phase returns to 0 after exactly 64 strobes.
- Envelope: attack_rate=16'h4000, gate0 held high:
  - level goes 4000, 8000, C000, FFFF; SUSTAIN on the 4th strobe.
  - gate0 low with release_rate=16'h8000 → 7FFF, then 0000; IDLE and env_active[0]=0 on the 2nd strobe.
- Full-scale square: voice0 square in SUSTAIN with p[MSB]=1, other voices off → voice sample 1022, mix_out 255; dout has exactly 255 ones in any 1024-clock window.
- Retrigger: gate0 high during RELEASE at level 16'h7FFF → ATTACK continues from 7FFF; phase is not cleared with SYNC_PHASE=1.
- Reset mid-attack: one-cycle rst while level=16'h8000 → state IDLE, level 0, mix_out 0 two cycles later.
